// File: rtl/steering_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// steering_ramp_ctrl
//
// Builds the 32-bit command word for the PWM steering driver. The host posts a
// target duty/direction over a valid/ready handshake; the controller slews the
// duty toward it by STEP once per ramp tick. Before a direction reversal it
// brings the duty to zero and then waits DEAD_TICKS ticks at zero. The stop bit
// is asserted while idle or faulted. A watchdog trips FAULT when the host stops
// refreshing commands while the controller is active.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   cmd_valid   host command valid
//   cmd_ready   controller can accept a command (low only in FAULT)
//   cmd_duty    target duty
//   cmd_dir     target direction
//   cmd_stop    stop request: target duty forced to 0, park in IDLE
//   fault_clr   single-cycle pulse that leaves FAULT
//   steer_word  registered word: [DATA_WIDTH-1]=stop, [DATA_WIDTH-2]=dir,
//               [COUNT_SIZE-1:0]=duty, all other bits 0
//   busy        high in RAMP or DEAD
//   fault       high in FAULT
// -----------------------------------------------------------------------------
module steering_ramp_ctrl #(
    parameter int COUNT_SIZE = 11,
    parameter int DATA_WIDTH = 32,
    parameter int STEP       = 8,
    parameter int TICK_DIV   = 2048,
    parameter int DEAD_TICKS = 4,
    parameter int WDOG_TICKS = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [COUNT_SIZE-1:0] cmd_duty,
    input  logic                  cmd_dir,
    input  logic                  cmd_stop,
    input  logic                  fault_clr,
    output logic [DATA_WIDTH-1:0] steer_word,
    output logic                  busy,
    output logic                  fault
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DEAD_W = $clog2(DEAD_TICKS + 1);
    localparam int WDOG_W = $clog2(WDOG_TICKS + 1);
    localparam int EXT_W  = COUNT_SIZE + 1;

    localparam logic [EXT_W-1:0] STEP_EXT = EXT_W'(STEP);
    localparam logic [EXT_W-1:0] DUTY_MAX = {1'b0, {COUNT_SIZE{1'b1}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP,
        ST_HOLD,
        ST_DEAD,
        ST_FAULT
    } state_t;

    state_t                state_reg, state_next;
    logic [COUNT_SIZE-1:0] cur_duty_reg, cur_duty_next;
    logic                  cur_dir_reg, cur_dir_next;
    logic [COUNT_SIZE-1:0] tgt_duty_reg, tgt_duty_next;
    logic                  tgt_dir_reg, tgt_dir_next;
    logic                  stop_pend_reg, stop_pend_next;
    logic [TICK_W-1:0]     tick_cnt_reg, tick_cnt_next;
    logic [DEAD_W-1:0]     dead_cnt_reg, dead_cnt_next;
    logic [WDOG_W-1:0]     wdog_cnt_reg, wdog_cnt_next;
    logic [DATA_WIDTH-1:0] steer_word_reg, steer_word_next;

    logic                  tick;
    logic                  accept;
    logic                  active;
    logic                  wdog_fault;
    logic                  dir_mismatch;
    logic                  tgt_change;
    logic                  stop_bit;
    logic [COUNT_SIZE-1:0] eff_duty;
    logic [EXT_W-1:0]      duty_ext;
    logic [EXT_W-1:0]      tgt_ext;
    logic [EXT_W-1:0]      ramp_ext;
    logic [COUNT_SIZE-1:0] ramp_duty;

    // Free-running tick divider; commands never re-align it.
    assign tick          = (tick_cnt_reg == TICK_W'(TICK_DIV - 1));
    assign tick_cnt_next = tick ? '0 : tick_cnt_reg + TICK_W'(1);

    assign cmd_ready    = (state_reg != ST_FAULT);
    assign busy         = (state_reg == ST_RAMP) || (state_reg == ST_DEAD);
    assign fault        = (state_reg == ST_FAULT);
    assign accept       = cmd_valid & cmd_ready;
    assign active       = (state_reg == ST_RAMP) || (state_reg == ST_HOLD) ||
                          (state_reg == ST_DEAD);
    assign eff_duty     = cmd_stop ? '0 : cmd_duty;
    assign dir_mismatch = (cur_dir_reg != tgt_dir_reg);

    // A stop request always counts as a new target so HOLD can reach IDLE
    // even when it is already parked at zero duty.
    assign tgt_change   = cmd_stop || (eff_duty != tgt_duty_reg) ||
                          (cmd_dir != tgt_dir_reg);

    // An accept in the expiry cycle refreshes the watchdog instead of faulting.
    assign wdog_fault   = active && tick && !accept &&
                          (wdog_cnt_reg == WDOG_W'(WDOG_TICKS - 1));

    // One ramp step, done one bit wider so the add/subtract can neither wrap
    // nor overshoot; the result is then clamped back to the duty range.
    always_comb begin
        duty_ext = {1'b0, cur_duty_reg};
        tgt_ext  = {1'b0, tgt_duty_reg};
        ramp_ext = duty_ext;
        if (dir_mismatch) begin
            ramp_ext = (duty_ext <= STEP_EXT) ? '0 : duty_ext - STEP_EXT;
        end else if (duty_ext < tgt_ext) begin
            ramp_ext = ((tgt_ext - duty_ext) <= STEP_EXT) ? tgt_ext : duty_ext + STEP_EXT;
        end else if (duty_ext > tgt_ext) begin
            ramp_ext = ((duty_ext - tgt_ext) <= STEP_EXT) ? tgt_ext : duty_ext - STEP_EXT;
        end
        ramp_duty = (ramp_ext > DUTY_MAX) ? DUTY_MAX[COUNT_SIZE-1:0] : ramp_ext[COUNT_SIZE-1:0];
    end

    always_comb begin
        state_next     = state_reg;
        cur_duty_next  = cur_duty_reg;
        cur_dir_next   = cur_dir_reg;
        tgt_duty_next  = tgt_duty_reg;
        tgt_dir_next   = tgt_dir_reg;
        stop_pend_next = stop_pend_reg;
        dead_cnt_next  = (state_reg == ST_DEAD) ? dead_cnt_reg : '0;
        wdog_cnt_next  = wdog_cnt_reg;

        // New target is latched here but only steers the ramp from next cycle.
        if (accept) begin
            tgt_duty_next  = eff_duty;
            tgt_dir_next   = cmd_dir;
            stop_pend_next = cmd_stop;
        end

        if (!active || accept) begin
            wdog_cnt_next = '0;
        end else if (tick) begin
            wdog_cnt_next = wdog_cnt_reg + WDOG_W'(1);
        end

        if (wdog_fault) begin
            state_next    = ST_FAULT;
            cur_duty_next = '0;
            wdog_cnt_next = '0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    // Duty is already zero, so the direction can change at once.
                    if (accept && !cmd_stop) begin
                        cur_dir_next = cmd_dir;
                        state_next   = ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    if (tick) begin
                        if (dir_mismatch && (cur_duty_reg == '0)) begin
                            state_next = ST_DEAD;
                        end else begin
                            cur_duty_next = ramp_duty;
                            // Settling is judged against the old target; if a
                            // new one arrived this cycle, keep ramping.
                            if (!dir_mismatch && (ramp_duty == tgt_duty_reg) && !accept) begin
                                state_next = stop_pend_reg ? ST_IDLE : ST_HOLD;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (accept && tgt_change) begin
                        state_next = ST_RAMP;
                    end
                end
                ST_DEAD: begin
                    if (tick) begin
                        if (dead_cnt_reg == DEAD_W'(DEAD_TICKS - 1)) begin
                            cur_dir_next  = tgt_dir_reg;
                            dead_cnt_next = '0;
                            state_next    = ST_RAMP;
                        end else begin
                            dead_cnt_next = dead_cnt_reg + DEAD_W'(1);
                        end
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        state_next     = ST_IDLE;
                        tgt_duty_next  = '0;
                        stop_pend_next = 1'b0;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Output word fields, assembled bit by bit from the current registers.
    assign stop_bit = (state_reg == ST_IDLE) || (state_reg == ST_FAULT);

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_word
            if (gi == DATA_WIDTH - 1) begin : g_stop
                assign steer_word_next[gi] = stop_bit;
            end else if (gi == DATA_WIDTH - 2) begin : g_dir
                assign steer_word_next[gi] = cur_dir_reg;
            end else if (gi < COUNT_SIZE) begin : g_duty
                assign steer_word_next[gi] = cur_duty_reg[gi];
            end else begin : g_zero
                assign steer_word_next[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cur_duty_reg   <= '0;
            cur_dir_reg    <= 1'b0;
            tgt_duty_reg   <= '0;
            tgt_dir_reg    <= 1'b0;
            stop_pend_reg  <= 1'b0;
            tick_cnt_reg   <= '0;
            dead_cnt_reg   <= '0;
            wdog_cnt_reg   <= '0;
            steer_word_reg <= {1'b1, {(DATA_WIDTH - 1){1'b0}}};
        end else begin
            state_reg      <= state_next;
            cur_duty_reg   <= cur_duty_next;
            cur_dir_reg    <= cur_dir_next;
            tgt_duty_reg   <= tgt_duty_next;
            tgt_dir_reg    <= tgt_dir_next;
            stop_pend_reg  <= stop_pend_next;
            tick_cnt_reg   <= tick_cnt_next;
            dead_cnt_reg   <= dead_cnt_next;
            wdog_cnt_reg   <= wdog_cnt_next;
            steer_word_reg <= steer_word_next;
        end
    end

    assign steer_word = steer_word_reg;

endmodule

// File: tb/tb_steering_ramp_ctrl.sv
`timescale 1ns/1ps
module tb_steering_ramp_ctrl;

    localparam int CS    = 11;
    localparam int DW    = 32;
    localparam int STEP  = 8;
    localparam int TDIV  = 4;
    localparam int DEADT = 2;
    localparam int WDOG  = 16;

    localparam int M_IDLE  = 0;
    localparam int M_RAMP  = 1;
    localparam int M_HOLD  = 2;
    localparam int M_DEAD  = 3;
    localparam int M_FAULT = 4;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [CS-1:0] cmd_duty  = '0;
    logic          cmd_dir   = 1'b0;
    logic          cmd_stop  = 1'b0;
    logic          fault_clr = 1'b0;
    logic          cmd_ready;
    logic          busy;
    logic          fault;
    logic [DW-1:0] steer_word;

    steering_ramp_ctrl #(
        .COUNT_SIZE(CS),
        .DATA_WIDTH(DW),
        .STEP      (STEP),
        .TICK_DIV  (TDIV),
        .DEAD_TICKS(DEADT),
        .WDOG_TICKS(WDOG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_duty  (cmd_duty),
        .cmd_dir   (cmd_dir),
        .cmd_stop  (cmd_stop),
        .fault_clr (fault_clr),
        .steer_word(steer_word),
        .busy      (busy),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] word;
        logic        busy;
        logic        fault;
        logic        ready;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    // Reference model: operating mode, actual and target duty/direction,
    // elapsed-tick counters, all as plain integers.
    int m_mode = M_IDLE;
    int m_duty = 0;
    int m_dir  = 0;
    int t_duty = 0;
    int t_dir  = 0;
    int t_stop = 0;
    int m_wd   = 0;
    int m_dead = 0;
    int m_ncyc = 0;
    int o_duty, o_dir, o_stop;
    bit m_tick, m_acc, m_active, m_expired;
    exp_t m_e;
    exp_t mon_e;
    exp_t mon_got;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = M_IDLE; m_duty = 0; m_dir = 0;
            t_duty = 0; t_dir = 0; t_stop = 0;
            m_wd = 0; m_dead = 0; m_ncyc = 0;
            m_e = '{word: 32'h8000_0000, busy: 1'b0, fault: 1'b0, ready: 1'b1};
        end else begin
            // Word shows the values held before this edge.
            m_e.word = ((m_mode == M_IDLE || m_mode == M_FAULT) ? 32'h8000_0000 : 32'h0) |
                       ((m_dir != 0) ? 32'h4000_0000 : 32'h0) | 32'(m_duty);
            m_tick = ((m_ncyc % TDIV) == TDIV - 1);
            m_ncyc++;
            m_acc    = cmd_valid && (m_mode != M_FAULT);
            m_active = (m_mode == M_RAMP || m_mode == M_HOLD || m_mode == M_DEAD);
            o_duty = t_duty; o_dir = t_dir; o_stop = t_stop;
            if (m_acc) begin
                t_duty = cmd_stop ? 0 : int'(cmd_duty);
                t_dir  = int'(cmd_dir);
                t_stop = int'(cmd_stop);
                $display("txn t=%0t duty=%0d dir=%0d stop=%0d from_mode=%0d",
                         $time, int'(cmd_duty), int'(cmd_dir), int'(cmd_stop), m_mode);
            end
            m_expired = 1'b0;
            if (m_active && m_tick && !m_acc) begin
                m_wd++;
                if (m_wd >= WDOG) m_expired = 1'b1;
            end
            if (m_acc || !m_active) m_wd = 0;

            if (m_expired) begin
                m_mode = M_FAULT; m_duty = 0; m_wd = 0; m_dead = 0;
            end else begin
                case (m_mode)
                    M_IDLE: begin
                        if (m_acc && !cmd_stop) begin
                            m_dir  = int'(cmd_dir);
                            m_mode = M_RAMP;
                        end
                    end
                    M_RAMP: begin
                        if (m_tick) begin
                            if (m_dir != o_dir) begin
                                if (m_duty == 0) begin
                                    m_mode = M_DEAD; m_dead = 0;
                                end else begin
                                    m_duty = (m_duty > STEP) ? m_duty - STEP : 0;
                                end
                            end else begin
                                if (m_duty < o_duty)
                                    m_duty = (m_duty + STEP < o_duty) ? m_duty + STEP : o_duty;
                                else if (m_duty > o_duty)
                                    m_duty = (m_duty - STEP > o_duty) ? m_duty - STEP : o_duty;
                                if (m_duty == o_duty && !m_acc)
                                    m_mode = (o_stop != 0) ? M_IDLE : M_HOLD;
                            end
                        end
                    end
                    M_HOLD: begin
                        if (m_acc && (cmd_stop || t_duty != o_duty || t_dir != o_dir))
                            m_mode = M_RAMP;
                    end
                    M_DEAD: begin
                        if (m_tick) begin
                            m_dead++;
                            if (m_dead == DEADT) begin
                                m_dir = o_dir; m_mode = M_RAMP; m_dead = 0;
                            end
                        end
                    end
                    default: begin
                        if (fault_clr) begin
                            m_mode = M_IDLE; t_duty = 0; t_stop = 0;
                        end
                    end
                endcase
            end
            m_e.busy  = (m_mode == M_RAMP || m_mode == M_DEAD);
            m_e.fault = (m_mode == M_FAULT);
            m_e.ready = (m_mode != M_FAULT);
        end
        exp_q.push_back(m_e);
    end

    // Monitor: the DUT presents a fresh word every cycle; compare it against
    // the expected response queued by the model.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_got = {steer_word, busy, fault, cmd_ready};
            n_cmp++;
            if (mon_got !== mon_e) begin
                n_mis++;
                $display("FAIL cycle t=%0t: got word=%h busy=%b fault=%b ready=%b, want word=%h busy=%b fault=%b ready=%b",
                         $time, mon_got.word, mon_got.busy, mon_got.fault, mon_got.ready,
                         mon_e.word, mon_e.busy, mon_e.fault, mon_e.ready);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic send(input int duty, input bit dir, input bit stop);
        cmd_valid = 1'b1;
        cmd_duty  = CS'(duty);
        cmd_dir   = dir;
        cmd_stop  = stop;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_stop  = 1'b0;
    endtask

    task automatic pulse_clr();
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
    endtask

    task automatic wait_word(input string name, input logic [31:0] want, input int budget);
        int k = 0;
        while (steer_word !== want && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, steer_word, want);
    endtask

    task automatic wait_fault(input string name, input int budget);
        int k = 0;
        while (fault !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(fault), 32'd1);
    endtask

    // Reset asserted between clock edges must clear the word at once.
    task automatic pulse_reset(input string name);
        #2 rst = 1'b1;
        #1 check(name, steer_word, 32'h8000_0000);
        check({name, "-busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic align_tick(input string name);
        int k = 0;
        while (!((m_ncyc % TDIV) == TDIV - 1) && k < 2 * TDIV) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'((m_ncyc % TDIV) == TDIV - 1), 32'd1);
    endtask

    initial begin
        int k;
        int sel, gap, duty, pick;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset-word", steer_word, 32'h8000_0000);
        check("reset-ready", 32'(cmd_ready), 32'd1);
        check("reset-busy", 32'(busy), 32'd0);
        repeat (8) @(negedge clk);

        // Asynchronous reset in the middle of a ramp
        send(500, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("ramp-busy", 32'(busy), 32'd1);
        pulse_reset("async-reset");
        repeat (4) @(negedge clk);

        // Ramp up from IDLE to 20, dir 1
        send(20, 1'b1, 1'b0);
        wait_word("ramp-start", 32'h4000_0000, 8);
        wait_word("ramp-8", 32'h4000_0008, 8);
        wait_word("hold-20", 32'h4000_0014, 16);
        check("hold-busy", 32'(busy), 32'd0);

        // Reversal: down to 0, dead time, flip, up to 12
        send(12, 1'b0, 1'b0);
        wait_word("rev-4", 32'h4000_0004, 16);
        wait_word("dead-zero", 32'h4000_0000, 8);
        wait_word("flip-8", 32'h0000_0008, 24);
        wait_word("rev-12", 32'h0000_000C, 8);

        // Long ramp to 2040 with periodic refreshes
        for (int i = 0; i < 60 && steer_word !== 32'h0000_07F8; i++) begin
            send(2040, 1'b0, 1'b0);
            repeat (30) @(negedge clk);
        end
        check("hold-2040", steer_word, 32'h0000_07F8);
        send(2047, 1'b0, 1'b0);
        wait_word("max-2047", 32'h0000_07FF, 12);
        check("max-busy", 32'(busy), 32'd0);

        // Stop: ramp down to zero and park in IDLE
        for (int i = 0; i < 60 && steer_word !== 32'h8000_0000; i++) begin
            send(0, 1'b0, 1'b1);
            repeat (30) @(negedge clk);
        end
        check("stop-idle", steer_word, 32'h8000_0000);

        // Watchdog expiry in HOLD
        send(20, 1'b0, 1'b0);
        wait_fault("wdog-fault", 200);
        @(negedge clk);
        check("fault-word", steer_word, 32'h8000_0000);
        check("fault-ready", 32'(cmd_ready), 32'd0);
        send(300, 1'b1, 1'b0);
        pulse_clr();
        check("clr-fault", 32'(fault), 32'd0);
        check("clr-ready", 32'(cmd_ready), 32'd1);

        // Accept exactly on the expiry tick: no fault, watchdog restarts
        send(20, 1'b0, 1'b0);
        k = 0;
        while (!(m_mode == M_HOLD && m_wd == WDOG - 1 && (m_ncyc % TDIV) == TDIV - 1) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("wdog-align", 32'(k < 300), 32'd1);
        send(20, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("wdog-accept-wins", 32'(fault), 32'd0);
        repeat (40) @(negedge clk);
        check("wdog-restart", 32'(fault), 32'd0);
        wait_fault("wdog-refault", 60);
        pulse_clr();

        // Accept on a ramp tick: that step still uses the old target
        send(20, 1'b0, 1'b0);
        wait_word("pre-20", 32'h0000_0014, 24);
        send(100, 1'b0, 1'b0);
        align_tick("tick-align");
        send(24, 1'b0, 1'b0);
        wait_word("old-target-step", 32'h0000_001C, 6);
        wait_word("new-target-24", 32'h0000_0018, 10);

        // Randomized traffic
        for (int it = 0; it < 250; it++) begin
            sel = int'($urandom_range(0, 99));
            gap = int'($urandom_range(0, 12));
            if (sel < 3) gap = 90;
            repeat (gap) @(negedge clk);
            if (sel >= 3 && sel < 5) pulse_reset("rand-reset");
            if (sel >= 5 && sel < 20) pulse_clr();
            pick = int'($urandom_range(0, 3));
            case (pick)
                0:       duty = int'($urandom_range(0, 40));
                1:       duty = int'($urandom_range(2030, 2047));
                2:       duty = int'($urandom_range(0, 2047));
                default: duty = t_duty;
            endcase
            send(duty, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/steering_ramp_ctrl.md
Name: steering_ramp_ctrl

Overview:
- Sequencer that generates the 32-bit steering command word for the PWM steering driver.
- Accepts target duty/direction commands from the host over a valid/ready handshake.
- Slews duty toward the target in fixed steps, forces a zero-duty dead time before any direction reversal, and asserts the stop bit when idle or when the host stops refreshing (watchdog).

Parameters:
- COUNT_SIZE, 11, width of the duty field; matches the PWM counter width.
- DATA_WIDTH, 32, width of the steering command word.
- STEP, 8, duty change applied per ramp tick.
- TICK_DIV, 2048, clocks per ramp tick (one PWM period at default); minimum 2.
- DEAD_TICKS, 4, ticks held at zero duty before the direction flips; minimum 1.
- WDOG_TICKS, 1024, ticks without an accepted command before FAULT; minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  controller can accept a command.
- cmd_duty  in  COUNT_SIZE  target duty.
- cmd_dir  in  1  target direction.
- cmd_stop  in  1  stop request; target duty is forced to 0 and the controller parks in IDLE.
- fault_clr  in  1  single-cycle pulse that clears FAULT.
- steer_word  out  DATA_WIDTH  command word to the steering driver.
- busy  out  1  high in RAMP or DEAD.
- fault  out  1  high in FAULT.

Behaviour:
- Reset (asynchronous, any state):
  - State = IDLE; cur_duty = 0; cur_dir = 0; tgt = 0.
  - Tick, dead and watchdog counters = 0.
  - steer_word = stop bit only; busy = 0; fault = 0; cmd_ready = 1.
- steer_word is registered:
  - bit DATA_WIDTH-1 = stop (1 in IDLE and FAULT, else 0).
  - bit DATA_WIDTH-2 = cur_dir.
  - bits COUNT_SIZE-1:0 = cur_duty.
  - All other bits 0.
  - steer_word reflects state/cur values one cycle after they change.
- Tick: free-running counter 0..TICK_DIV-1; tick pulses for one clk when the count = TICK_DIV-1. It runs continuously from reset and is never re-aligned by commands.
- Handshake:
  - cmd_ready = 1 in every state except FAULT.
  - Accept = cmd_valid & cmd_ready. On accept, latch tgt_duty (0 if cmd_stop), tgt_dir and stop_pend = cmd_stop, and clear the watchdog.
  - The latched target is used from the next cycle. A ramp step on a tick that coincides with an accept uses the old target.
- States:
  - IDLE: on accept with cmd_stop = 0, set cur_dir = tgt_dir directly (no dead time, duty already 0), then go to RAMP. An accept with cmd_stop = 1 stays in IDLE.
  - RAMP, on tick:
    - If cur_dir != tgt_dir: cur_duty = (cur_duty <= STEP) ? 0 : cur_duty - STEP. A tick with cur_duty = 0 goes to DEAD.
    - Else step toward tgt_duty by STEP, saturating exactly at tgt_duty with no overshoot and no wrap.
    - cur == tgt with matching dir goes to HOLD, or to IDLE if stop_pend.
  - HOLD: an accept that changes the target goes to RAMP. An accept of an identical target stays in HOLD and only refreshes the watchdog.
  - DEAD:
    - Duty is held at 0; dead counter increments on tick.
    - On the DEAD_TICKS-th tick: cur_dir = tgt_dir, clear the dead counter, go to RAMP.
    - An accept in DEAD restoring the original direction does not abort the dead time.
  - FAULT: cur_duty = 0 and stop = 1 on entry. fault_clr goes to IDLE with cur_dir retained and tgt = 0.
- Watchdog:
  - Increments on tick in RAMP, HOLD and DEAD; held at 0 in IDLE and FAULT.
  - Reaching WDOG_TICKS goes to FAULT, unless an accept occurs in the same cycle (accept wins).
- Arithmetic: duty math uses COUNT_SIZE+1 bits internally; results are clamped to 0..2^COUNT_SIZE-1.

Test Plan (bench parameters: TICK_DIV=4, STEP=8, DEAD_TICKS=2, WDOG_TICKS=16, COUNT_SIZE=11):
- Reset, then no stimulus -> steer_word = 0x80000000, cmd_ready = 1, busy = 0; apply rst mid-RAMP -> steer_word = 0x80000000 immediately (asynchronous).
- Command duty = 20, dir = 1 from IDLE -> steer_word 0x40000000, then duty 8, 16, 20 on successive ticks; busy drops and HOLD is entered at 20.
- In HOLD at duty 20/dir 1, command duty = 12, dir = 0:
  - Duty steps 12, 4, 0 on successive ticks.
  - DEAD follows for 2 ticks with duty 0 and dir 1.
  - Dir then flips to 0 and duty ramps 8, 12.
- Command duty = 2047, dir = 0 from HOLD at 2040 -> duty reaches 2047 in one tick with no wrap; cmd_stop then ramps the duty to 0 and ends in IDLE with bit 31 = 1.
- No command for 16 ticks in HOLD -> fault = 1, steer_word = 0x80000000 (dir bit retained), cmd_ready = 0; fault_clr -> IDLE, cmd_ready = 1.
- Accept in the same cycle as watchdog expiry -> no FAULT and the watchdog restarts; accept in the same cycle as a tick -> that step uses the old target.
